// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus arbiter. Each functional unit owns one holding
// slot (busy/tag/value); a round-robin search picks one busy slot per cycle
// and broadcasts it on registered CDB outputs.
// Optional build macro: CDB_STATS_EN adds bcast_count/stall_count outputs.
module cdb_arbiter #(
    parameter int NUM_FU = 5,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_FU-1:0]        fu_done,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_value,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic                     squash,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_value,
`ifdef CDB_STATS_EN
    output logic [31:0]              bcast_count,
    output logic [31:0]              stall_count,
`endif
    output logic [NUM_FU-1:0]        cdb_fu
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int PW1   = PTR_W + 1;

    // Holding slots, one per functional unit
    logic [NUM_FU-1:0] busy_q;
    logic [NUM_FU-1:0] busy_d;
    logic [TAG_W-1:0]  slot_tag_q   [NUM_FU];
    logic [DATA_W-1:0] slot_value_q [NUM_FU];

    // Round-robin pointer: the slot searched first on the next grant
    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] rr_ptr_d;

    // Grant selection
    logic [PTR_W-1:0]  rot_idx [NUM_FU];
    logic              grant_any;
    logic [PTR_W-1:0]  grant_idx;
    logic [NUM_FU-1:0] grant_oh;
    logic [NUM_FU-1:0] accept;

    // Registered broadcast stage
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
    logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
    logic [NUM_FU-1:0] cdb_fu_q,    cdb_fu_d;

    genvar gi;

    // rot_idx[k] is the slot visited k steps after rr_ptr, wrapping at NUM_FU.
    // rr_ptr is always below NUM_FU, so one conditional subtract suffices.
    for (gi = 0; gi < NUM_FU; gi++) begin : g_rot
        logic [PTR_W:0] sum;
        assign sum          = {1'b0, rr_ptr_q} + PW1'(gi);
        assign rot_idx[gi]  = (sum >= PW1'(NUM_FU)) ? PTR_W'(sum - PW1'(NUM_FU))
                                                    : sum[PTR_W-1:0];
    end

    // Pick the first busy slot in rotated order; scanning backwards lets the
    // earliest hit win without a break.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (busy_q[rot_idx[k]]) begin
                grant_any = 1'b1;
                grant_idx = rot_idx[k];
            end
        end
    end

    // One-hot grant, ready and accept per slot. A slot being granted this
    // cycle frees up at the edge, so it may be reloaded in the same cycle.
    // Nothing is accepted while reset or squash is active.
    for (gi = 0; gi < NUM_FU; gi++) begin : g_slot
        assign grant_oh[gi] = grant_any && (grant_idx == PTR_W'(gi));
        assign fu_ready[gi] = (!busy_q[gi] || grant_oh[gi]) && !squash && !reset;
        assign accept[gi]   = fu_done[gi] && fu_ready[gi];
    end

    // Busy bits: squash empties everything; otherwise the granted slot drains
    // and any accepted slot fills (a reload wins over the drain).
    always_comb begin
        busy_d = (busy_q & ~grant_oh) | accept;
        if (squash) begin
            busy_d = '0;
        end
    end

    // Broadcast next-state: the granted slot goes out unless squashed; when
    // idle, valid and source drop while tag/value keep their last contents.
    always_comb begin
        cdb_valid_d = 1'b0;
        cdb_fu_d    = '0;
        cdb_tag_d   = cdb_tag_q;
        cdb_value_d = cdb_value_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_any && !squash) begin
            cdb_valid_d = 1'b1;
            cdb_fu_d    = grant_oh;
            cdb_tag_d   = slot_tag_q[grant_idx];
            cdb_value_d = slot_value_q[grant_idx];
            rr_ptr_d    = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0
                                                            : grant_idx + PTR_W'(1);
        end
    end

    // Control state and broadcast register update
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q      <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_fu_q    <= '0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
        end else begin
            busy_q      <= busy_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_fu_q    <= cdb_fu_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
        end
    end

    // Slot payload storage; only written on accept, contents are meaningless
    // while the busy bit is clear so no reset is needed.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
                slot_tag_q[i]   <= fu_tag[i*TAG_W +: TAG_W];
                slot_value_q[i] <= fu_value[i*DATA_W +: DATA_W];
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_value = cdb_value_q;
    assign cdb_fu    = cdb_fu_q;

`ifdef CDB_STATS_EN
    logic [31:0] bcast_count_q;
    logic [31:0] stall_count_q;

    // Broadcast and stall event counters; frozen during squash
    always_ff @(posedge clock) begin
        if (reset) begin
            bcast_count_q <= '0;
            stall_count_q <= '0;
        end else if (!squash) begin
            if (cdb_valid_d) begin
                bcast_count_q <= bcast_count_q + 32'd1;
            end
            if (|(fu_done & ~fu_ready)) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign bcast_count = bcast_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter (default parameters: 5 FUs, 6-bit tags,
// 32-bit values). Inputs change 1ns after the rising edge; registered
// outputs are checked there, combinational fu_ready 1ns later.
module tb_cdb_arbiter;

    localparam int NUM_FU = 5;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    logic                     clock;
    logic                     reset;
    logic [NUM_FU-1:0]        fu_done;
    logic [NUM_FU*TAG_W-1:0]  fu_tag;
    logic [NUM_FU*DATA_W-1:0] fu_value;
    logic [NUM_FU-1:0]        fu_ready;
    logic                     squash;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_value;
    logic [NUM_FU-1:0]        cdb_fu;
`ifdef CDB_STATS_EN
    logic [31:0]              bcast_count;
    logic [31:0]              stall_count;
    logic [31:0]              bcast_before;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    cdb_arbiter #(
        .NUM_FU (NUM_FU),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .fu_done   (fu_done),
        .fu_tag    (fu_tag),
        .fu_value  (fu_value),
        .fu_ready  (fu_ready),
        .squash    (squash),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
`ifdef CDB_STATS_EN
        .bcast_count (bcast_count),
        .stall_count (stall_count),
`endif
        .cdb_fu    (cdb_fu)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One line per broadcast seen on the bus
    always @(negedge clock) begin
        if (cdb_valid) begin
            $display("[%0t] bcast tag=0x%0h value=0x%0h fu=%b", $time, cdb_tag, cdb_value, cdb_fu);
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        fu_done  = '0;
        fu_tag   = '0;
        fu_value = '0;
        squash   = 1'b0;
    endtask

    task automatic set_fu(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
        fu_done[i]                 = 1'b1;
        fu_tag[i*TAG_W +: TAG_W]   = t;
        fu_value[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic check_bcast(input string tag, input logic [TAG_W-1:0] t, input logic [NUM_FU-1:0] f);
        check({tag, "_valid"}, cdb_valid, 1'b1);
        check({tag, "_tag"},   cdb_tag,   t);
        check({tag, "_fu"},    cdb_fu,    f);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        do_reset();

        // ---- reset state ----
        check("rst_valid", cdb_valid, 1'b0);
        check("rst_fu",    cdb_fu,    5'b00000);
        check("rst_tag",   cdb_tag,   6'h00);
        check("rst_value", cdb_value, 32'h0);
        #1;
        check("rst_ready", fu_ready, 5'b11111);

        // ---- single completion from FU1 ----
        set_fu(1, 6'h0A, 32'h1234);
        #1;
        check("single_ready_in", fu_ready, 5'b11111);
        step();                             // accepted
        clear_inputs();
        check("single_lat_valid", cdb_valid, 1'b0);
        step();                             // broadcast
        check_bcast("single", 6'h0A, 5'b00010);
        check("single_value", cdb_value, 32'h1234);
        step();
        check("single_after_valid", cdb_valid, 1'b0);
        check("single_after_fu",    cdb_fu,    5'b00000);
        check("single_tag_hold",    cdb_tag,   6'h0A);

        // ---- contention: all FUs at once, rr_ptr = 0 after reset ----
        do_reset();
        for (int i = 0; i < NUM_FU; i++) set_fu(i, 6'(i + 1), 32'h100 + 32'(i + 1));
        step();
        clear_inputs();
        #1;
        check("cont_ready0", fu_ready, 5'b00001);
        step();
        check_bcast("cont1", 6'h01, 5'b00001);
        check("cont_ready1", fu_ready, 5'b00011);
        step();
        check_bcast("cont2", 6'h02, 5'b00010);
        check("cont_ready2", fu_ready, 5'b00111);
        step();
        check_bcast("cont3", 6'h03, 5'b00100);
        check("cont_ready3", fu_ready, 5'b01111);
        step();
        check_bcast("cont4", 6'h04, 5'b01000);
        check("cont_ready4", fu_ready, 5'b11111);
        step();
        check_bcast("cont5", 6'h05, 5'b10000);
        check("cont5_value", cdb_value, 32'h105);
        step();
        check("cont_idle", cdb_valid, 1'b0);
        // rr_ptr is now 0

        // ---- back-to-back on FU2 ----
        set_fu(2, 6'h07, 32'h7);
        #1;
        check("b2b_ready_a", fu_ready[2], 1'b1);
        step();
        set_fu(2, 6'h08, 32'h8);
        #1;
        check("b2b_ready_b", fu_ready[2], 1'b1);
        step();
        clear_inputs();
        check_bcast("b2b_7", 6'h07, 5'b00100);
        check("b2b_ready_c", fu_ready[2], 1'b1);
        step();
        check_bcast("b2b_8", 6'h08, 5'b00100);
        check("b2b_8_value", cdb_value, 32'h8);
        step();
        check("b2b_idle", cdb_valid, 1'b0);
        // rr_ptr is now 3

        // ---- fairness: FU0 streams, FU3 once ----
        set_fu(0, 6'h20, 32'h20);
        step();                                 // 0x20 accepted
        set_fu(0, 6'h21, 32'h21);
        set_fu(3, 6'h33, 32'h33);
        #1;
        check("fair_ready_b", fu_ready, 5'b11111);
        step();                                 // bcast 0x20, accept 0x21 and 0x33
        check_bcast("fair_20", 6'h20, 5'b00001);
        clear_inputs();
        set_fu(0, 6'h22, 32'h22);
        #1;
        check("fair_fu0_blocked", fu_ready[0], 1'b0);
        step();                                 // FU3 must win over FU0
        check_bcast("fair_33", 6'h33, 5'b01000);
        #1;
        check("fair_fu0_ready", fu_ready[0], 1'b1);
        step();                                 // bcast 0x21, accept 0x22
        clear_inputs();
        check_bcast("fair_21", 6'h21, 5'b00001);
        step();
        check_bcast("fair_22", 6'h22, 5'b00001);
        step();
        check("fair_idle", cdb_valid, 1'b0);
        // rr_ptr is now 1

        // ---- squash with three busy slots and a new request ----
        for (int i = 0; i < 3; i++) set_fu(i, 6'h30 + 6'(i), 32'h300 + 32'(i));
        step();                                 // three slots loaded
        clear_inputs();
        squash = 1'b1;
        set_fu(4, 6'h34, 32'h334);
        #1;
        check("sq_ready", fu_ready, 5'b00000);
`ifdef CDB_STATS_EN
        bcast_before = bcast_count;
`endif
        step();
        clear_inputs();
        check("sq_valid", cdb_valid, 1'b0);
        check("sq_fu",    cdb_fu,    5'b00000);
`ifdef CDB_STATS_EN
        check("sq_bcast_count", bcast_count, bcast_before);
`endif
        #1;
        check("sq_ready_after", fu_ready, 5'b11111);
        for (int c = 0; c < 6; c++) begin
            step();
            check("sq_no_bcast", cdb_valid, 1'b0);
        end

        // ---- reset mid-operation with four busy slots ----
        for (int i = 0; i < 4; i++) set_fu(i, 6'h28 + 6'(i), 32'h400 + 32'(i));
        step();                                 // four slots loaded
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_valid", cdb_valid, 1'b0);
        check("mid_rst_tag",   cdb_tag,   6'h00);
        #1;
        check("mid_rst_ready", fu_ready, 5'b11111);
        for (int c = 0; c < 6; c++) begin
            step();
            check("mid_rst_no_bcast", cdb_valid, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_FU, default 5, giving the number of functional-unit completion ports.
REQ-002 The block SHALL have parameter TAG_W, default 6, giving the physical-register tag width.
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the result value width.
REQ-004 Port clock  input  1  rising-edge clock.
REQ-005 Port reset  input  1  reset, synchronous, active-high.
REQ-006 Port fu_done  input  NUM_FU  per-FU completion request.
REQ-007 Port fu_tag  input  NUM_FU x TAG_W  per-FU destination tag.
REQ-008 Port fu_value  input  NUM_FU x DATA_W  per-FU result value.
REQ-009 Port fu_ready  output  NUM_FU  per-FU holding slot can accept this cycle.
REQ-010 Port squash  input  1  mispredict flush; discards all pending completions.
REQ-011 Port cdb_valid  output  1  broadcast valid, registered.
REQ-012 Port cdb_tag  output  TAG_W  broadcast tag, registered; this drives the reservation station's cdb_ready/cdb_tag.
REQ-013 Port cdb_value  output  DATA_W  broadcast value, registered.
REQ-014 Port cdb_fu  output  NUM_FU  one-hot source FU of the current broadcast, registered.

Function
REQ-015 The block SHALL hold one slot per FU: busy bit, tag, value.
REQ-016 fu_ready[i] SHALL be combinationally (!busy[i] || grant[i]) && !squash.
REQ-017 A completion SHALL be accepted at an edge only when fu_done[i] && fu_ready[i]; the slot is then loaded and busy[i] set.
REQ-018 fu_done[i] while fu_ready[i]=0 SHALL be ignored; the FU holds its request until ready.
REQ-019 Grant: combinationally, at most one busy slot SHALL be chosen, by round-robin search starting at rr_ptr and wrapping from NUM_FU-1 to 0.
REQ-020 At each edge with a grant g: cdb_valid<=1, cdb_tag/cdb_value<=slot g, cdb_fu<=one-hot g, busy[g] cleared unless reloaded the same edge, rr_ptr<=(g+1) mod NUM_FU.
REQ-021 At an edge with no busy slot: cdb_valid<=0, cdb_fu<=0; cdb_tag/cdb_value hold; rr_ptr holds.
REQ-022 Latency: completion accepted at edge N SHALL be broadcast no earlier than after edge N+1, and at most NUM_FU edges after N under continuous contention.
REQ-023 Simultaneous grant and new accept on the same slot SHALL broadcast the old contents and store the new ones (no loss, no duplicate).
REQ-024 Exactly one broadcast per accepted completion SHALL occur unless squashed.
REQ-025 squash at an edge SHALL clear all busy bits, set cdb_valid<=0 and cdb_fu<=0, and accept nothing; rr_ptr holds.
REQ-026 All slots full SHALL deassert fu_ready for every FU not granted that cycle.

Reset
REQ-027 On reset: all busy<=0, rr_ptr<=0, cdb_valid<=0, cdb_fu<=0, cdb_tag<=0, cdb_value<=0, and no request is accepted.
REQ-028 Reset asserted mid-operation SHALL discard all pending completions; fu_ready SHALL be 1 for all FUs in the first cycle after reset deasserts.

Configuration
REQ-029 With macro CDB_STATS_EN defined, the block SHALL add outputs bcast_count (32 bits, incremented on every edge with cdb_valid<=1) and stall_count (32 bits, incremented on every edge where any fu_done[i] && !fu_ready[i]), both cleared by reset and held by squash.
REQ-030 Without CDB_STATS_EN, those outputs and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-031 Single: after reset, fu_done[1]=1, tag=0x0A, value=0x1234 for one cycle -> one cycle later cdb_valid=1, cdb_tag=0x0A, cdb_value=0x1234, cdb_fu=5'b00010; the next cycle cdb_valid=0.
REQ-032 Contention: all 5 FUs request tags 1..5 in the same cycle with rr_ptr=0 -> broadcasts of tags 1,2,3,4,5 on 5 consecutive cycles; fu_ready=0 for slots still busy.
REQ-033 Fairness: FU0 requests every cycle, FU3 requests once -> FU3 is broadcast within 2 broadcasts, and FU0 is never granted twice in a row while FU3 is pending.
REQ-034 Back-to-back: FU2 requests tags 7 then 8 on consecutive cycles, no other traffic -> cdb_tag=7 then 8 on consecutive cycles, fu_ready[2] stays 1.
REQ-035 Squash: 3 slots busy, squash=1 with fu_done[4]=1 -> next cycle cdb_valid=0, no later broadcast of any of the 4 tags; with CDB_STATS_EN, bcast_count is unchanged.
REQ-036 Reset mid-op: 4 slots busy, reset for 1 cycle -> cdb_valid=0 and all fu_ready=1 after reset, and no stale tag is ever broadcast.
